systolic_post_act: RTL
======================

// Module: systolic_post_act
// PURPOSE
//  Downstream stage of the 6x6 systolic array. Takes each 6-lane result vector y0..y5
//  (signed Q(WIDTH-FRAC_BIT).FRAC_BIT), adds a per-lane bias with saturation and
//  applies ReLU. Buffers results in a small FIFO behind a valid/ready handshake.
//  Marks the last vector of each NUM_VEC-vector block for the next layer's loader.
// PARAMETERS
//  WIDTH      16  lane data width, signed two's complement
//  FRAC_BIT   10  fractional bits (pass-through; bias shares the same Q format)
//  DEPTH      4   output FIFO entries, >=2, power of two
//  NUM_VEC    5   vectors per block; out_last marks vector NUM_VEC-1
//  LEAK_SHIFT 3   leaky-ReLU slope 2^-LEAK_SHIFT (used only with LEAKY_RELU_EN)
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  clr          in   1      synchronous flush: pipeline, FIFO, counter, sat_flag
//  in_valid     in   1      y0..y5 carry a valid vector
//  in_ready     out  1      stage can accept a vector this cycle
//  y0..y5       in   WIDTH  systolic array outputs, one per lane
//  bias0..bias5 in   WIDTH  per-lane bias, quasi-static (sampled on accept)
//  out_valid    out  1      z0..z5 hold a valid vector
//  out_ready    in   1      consumer accepts the vector this cycle
//  z0..z5       out  WIDTH  activated lane results (FIFO head)
//  out_last     out  1      head vector is index NUM_VEC-1 of its block
//  sat_flag     out  1      sticky: a bias add saturated since last rst/clr
// BEHAVIOUR
//  - Reset (rst=1): out_valid=0, z0..z5=0, out_last=0, sat_flag=0, FIFO empty,
//    S1 empty, vector counter=0. in_ready=1 on the first cycle after reset.
//  - Priority: rst > clr > normal operation. clr acts like rst but is a separate
//    input. It drops in-flight vectors and wins over a same-cycle accept or pop.
//  - Accept: in_valid & in_ready. Pop: out_valid & out_ready.
//  - in_ready = (s1_valid + fifo_count) < DEPTH. This is combinational from registered
//    state only, with no out_ready path. An overflow is therefore impossible.
//  - S1 (register): per lane, sum = sext(y)+sext(bias) in WIDTH+1 bits. The result
//    clamps to 0x7FFF/0x8000 (for WIDTH=16) when the top two bits differ. Any lane
//    clamping sets sat_flag on the accept cycle.
//  - S2: activation happens when S1 is written into the FIFO. Negative values become 0.
//    Non-negative values pass unchanged. S1 always drains into the FIFO the next cycle,
//    since its space is reserved by in_ready.
//  - Latency: accept in cycle N -> out_valid with data in cycle N+2 when FIFO is empty.
//    Throughput is 1 vector/cycle with out_ready held high.
//  - FIFO: in-order, with a registered head on z0..z5. Simultaneous push and pop is
//    legal at any count, including full. Pop when empty cannot occur.
//  - While out_valid=0, z0..z5 and out_last hold their last value. Consumers must
//    gate on out_valid.
//  - out_last: the counter tags each vector entering the FIFO, wrapping
//    NUM_VEC-1 -> 0. out_last travels with the data.
//  - Holding: while out_valid & !out_ready, z*/out_last are stable.
// CONFIGURATION
//  - LEAKY_RELU_EN defined: negative activations become (value >>> LEAK_SHIFT),
//    an arithmetic shift rounding toward -inf.
//  - Not defined: plain ReLU, negatives become 0. LEAK_SHIFT is unused.
//  - Ports, latency and handshake are identical in both builds.
// TESTING
//  1. y0=0x0400, bias0=0x0200, one accept -> z0=0x0600 with out_valid two cycles later.
//     Other lanes with y=bias=0 -> 0.
//  2. y1=0xFB33, bias1=0 -> z1=0x0000. With LEAKY_RELU_EN and LEAK_SHIFT=3 -> z1=0xFF66.
//  3. y2=0x7000, bias2=0x2000 -> z2=0x7FFF and sat_flag=1 until clr.
//     y3=0x8000, bias3=0xC000 -> clamps to 0x8000 -> z3=0, sat_flag=1.
//  4. Streaming 12 vectors with out_ready=0 for the first 8 cycles -> exactly 4
//     accepted, then in_ready=0. After release, all 12 exit in order with no loss or
//     duplicate.
//  5. NUM_VEC=5, 10 back-to-back vectors, out_ready=1 -> out_last=1 on the 5th and
//     10th outputs only.
//  6. clr pulsed with 3 vectors in flight -> next cycle out_valid=0, in_ready=1,
//     sat_flag=0. The next vector gets counter index 0. rst pulse -> same result.

Source files
------------

// File: rtl/systolic_post_act.sv
// -----------------------------------------------------------------------------
// systolic_post_act
//
// Downstream stage of the 6x6 systolic array. Each accepted 6-lane result
// vector goes through two steps:
//   S1 (register): per-lane bias add with saturation to the signed WIDTH range.
//   S2 (on FIFO write): activation, which is plain ReLU or leaky ReLU.
// Results then wait in a DEPTH-entry in-order FIFO. The FIFO head is
// registered onto z0..z5 / out_last.
// A vector counter tags each vector as it enters the FIFO, so out_last marks
// vector NUM_VEC-1 of every NUM_VEC-vector block.
//
// Build option:
//   LEAKY_RELU_EN  defined   -> a negative activation becomes value >>> LEAK_SHIFT
//                  undefined -> a negative activation becomes 0 (plain ReLU)
//
// Handshake: a transfer happens on any rising edge where valid & ready are
// both high. Input side: in_valid/in_ready. Output side: out_valid/out_ready.
// in_ready depends only on registered state. While out_valid is high and
// out_ready is low, z0..z5 and out_last stay stable.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   clr                 synchronous flush (pipeline, FIFO, counter, sat_flag)
//   in_valid, in_ready  input handshake
//   y0..y5              lane inputs, signed Q(WIDTH-FRAC_BIT).FRAC_BIT
//   bias0..bias5        per-lane bias, sampled on accept
//   out_valid, out_ready output handshake
//   z0..z5              activated lane results (FIFO head)
//   out_last            head vector is index NUM_VEC-1 of its block
//   sat_flag            sticky, set when any bias add saturated
// -----------------------------------------------------------------------------
module systolic_post_act #(
   parameter int WIDTH      = 16,
   parameter int FRAC_BIT   = 10,
   parameter int DEPTH      = 4,
   parameter int NUM_VEC    = 5,
   parameter int LEAK_SHIFT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] y0,
   input  logic [WIDTH-1:0] y1,
   input  logic [WIDTH-1:0] y2,
   input  logic [WIDTH-1:0] y3,
   input  logic [WIDTH-1:0] y4,
   input  logic [WIDTH-1:0] y5,
   input  logic [WIDTH-1:0] bias0,
   input  logic [WIDTH-1:0] bias1,
   input  logic [WIDTH-1:0] bias2,
   input  logic [WIDTH-1:0] bias3,
   input  logic [WIDTH-1:0] bias4,
   input  logic [WIDTH-1:0] bias5,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z0,
   output logic [WIDTH-1:0] z1,
   output logic [WIDTH-1:0] z2,
   output logic [WIDTH-1:0] z3,
   output logic [WIDTH-1:0] z4,
   output logic [WIDTH-1:0] z5,
   output logic             out_last,
   output logic             sat_flag
);

   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CTW = $clog2(DEPTH) + 1;
   localparam int VW  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   // FIFO entry: {last, lane5, ..., lane0}
   localparam int EW  = 6 * WIDTH + 1;

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Reject unusable parameter sets at elaboration time.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_VEC < 1 ||
       FRAC_BIT >= WIDTH || LEAK_SHIFT >= WIDTH) begin : g_bad_param
      $error("systolic_post_act: unsupported parameter combination");
   end

   // ---------------------------------------------------------------- lanes
   logic [WIDTH-1:0] y_lane [6];
   logic [WIDTH-1:0] b_lane [6];

   assign y_lane[0] = y0;    assign b_lane[0] = bias0;
   assign y_lane[1] = y1;    assign b_lane[1] = bias1;
   assign y_lane[2] = y2;    assign b_lane[2] = bias2;
   assign y_lane[3] = y3;    assign b_lane[3] = bias3;
   assign y_lane[4] = y4;    assign b_lane[4] = bias4;
   assign y_lane[5] = y5;    assign b_lane[5] = bias5;

   // ---------------------------------------------------------------- bias add
   logic [WIDTH:0]   sum_wide [6];
   logic [WIDTH-1:0] sum_sat  [6];
   logic [5:0]       lane_sat;

   // When the two top bits of the WIDTH+1-bit sum differ, the result does
   // not fit in WIDTH bits. The true sign (top bit) picks the clamp value.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         sum_wide[i] = {y_lane[i][WIDTH-1], y_lane[i]} + {b_lane[i][WIDTH-1], b_lane[i]};
         lane_sat[i] = sum_wide[i][WIDTH] ^ sum_wide[i][WIDTH-1];
         if (lane_sat[i])
            sum_sat[i] = sum_wide[i][WIDTH] ? SAT_MIN : SAT_MAX;
         else
            sum_sat[i] = sum_wide[i][WIDTH-1:0];
      end
   end

   // ---------------------------------------------------------------- state
   logic             s1_valid;
   logic [WIDTH-1:0] s1_data [6];
   logic [EW-1:0]    mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CTW-1:0]   count;
   logic [VW-1:0]    vec_cnt;
   logic [EW-1:0]    head_q;
   logic             out_valid_q;
   logic             sat_q;

   logic accept;
   logic push;
   logic pop;

   // S1 holds a reserved FIFO slot, so it always drains on the next cycle.
   assign in_ready = ({1'b0, count} + {{CTW{1'b0}}, s1_valid}) < (CTW + 1)'(DEPTH);
   assign accept   = in_valid & in_ready;
   assign push     = s1_valid;
   assign pop      = out_valid_q & out_ready;

   // ---------------------------------------------------------------- activation
   function automatic logic [WIDTH-1:0] activate(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = v;
      if (v[WIDTH-1]) begin
`ifdef LEAKY_RELU_EN
         r = $signed(v) >>> LEAK_SHIFT;
`else
         r = '0;
`endif
      end
      return r;
   endfunction

   logic [EW-1:0] push_entry;

   always_comb begin
      push_entry = '0;
      for (int i = 0; i < 6; i++)
         push_entry[i*WIDTH +: WIDTH] = activate(s1_data[i]);
      push_entry[EW-1] = (vec_cnt == VW'(NUM_VEC - 1));
   end

   // ---------------------------------------------------------------- FIFO next state
   logic [PW-1:0]  rd_next;
   logic [CTW-1:0] count_next;
   logic [EW-1:0]  head_next;

   // The head register always shows the entry at the read pointer. If that
   // entry is being written this cycle, the value comes from the bypass path.
   always_comb begin
      rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
      count_next = count + CTW'(push) - CTW'(pop);
      head_next  = (push && (rd_next == wr_ptr)) ? push_entry : mem[rd_next];
   end

   // Storage array is not reset. Only entries behind a valid count are read.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         s1_valid    <= 1'b0;
         for (int i = 0; i < 6; i++)
            s1_data[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         vec_cnt     <= '0;
         head_q      <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            for (int i = 0; i < 6; i++)
               s1_data[i] <= sum_sat[i];
            if (|lane_sat)
               sat_q <= 1'b1;
         end

         if (push) begin
            wr_ptr  <= wr_ptr + PW'(1);
            vec_cnt <= (vec_cnt == VW'(NUM_VEC - 1)) ? '0 : vec_cnt + VW'(1);
         end

         rd_ptr      <= rd_next;
         count       <= count_next;
         out_valid_q <= (count_next != '0);
         // While the FIFO is empty, the last head value is held.
         if (count_next != '0)
            head_q <= head_next;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign out_valid = out_valid_q;
   assign sat_flag  = sat_q;
   assign z0        = head_q[0*WIDTH +: WIDTH];
   assign z1        = head_q[1*WIDTH +: WIDTH];
   assign z2        = head_q[2*WIDTH +: WIDTH];
   assign z3        = head_q[3*WIDTH +: WIDTH];
   assign z4        = head_q[4*WIDTH +: WIDTH];
   assign z5        = head_q[5*WIDTH +: WIDTH];
   assign out_last  = head_q[EW-1];

endmodule
